// File: rtl/dmem_mmio.sv
// dmem_mmio: data-memory responder for the single-cycle MIPS core.
// Word RAM at the bottom of the address space plus a peripheral page at
// 0xFFFF_0000: GPIO output register, free-running cycle counter and an
// optional FIFO-buffered 8N1 UART transmitter (enabled by DMEM_UART_EN).
// Reads are combinational; writes commit on the rising edge of clk.
//
// Transmitter states:
//   state   | meaning
//   S_IDLE  | line high, waiting for a byte in the FIFO
//   S_START | start bit (low) for CLKS_PER_BIT cycles
//   S_DATA  | 8 data bits, LSB first, CLKS_PER_BIT cycles each
//   S_STOP  | stop bit (high); may chain straight into the next frame
module dmem_mmio #(
   parameter int DEPTH        = 64,
   parameter int FIFO_DEPTH   = 4,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [31:0] a,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic [7:0]  gpio_out,
   output logic        uart_tx
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [31:0] GPIO_ADDR  = 32'hFFFF_0000;
   localparam logic [31:0] CNT_ADDR   = 32'hFFFF_0004;
   localparam logic [31:0] UDATA_ADDR = 32'hFFFF_0008;
   localparam logic [31:0] USTAT_ADDR = 32'hFFFF_000C;

   if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CLKS_PER_BIT < 2) begin : g_bad_cfg
      $error("dmem_mmio: illegal DEPTH/FIFO_DEPTH/CLKS_PER_BIT");
   end

   logic [31:0] mem [DEPTH];
   logic [31:0] a_word;
   logic [31:0] cycle_cnt;
   logic        ram_sel;
   logic        gpio_sel;
   logic        cnt_sel;

   // byte offset bits are irrelevant: every access is a full word
   assign a_word   = a & ~32'h3;
   assign ram_sel  = a_word < 32'(DEPTH * 4);
   assign gpio_sel = a_word == GPIO_ADDR;
   assign cnt_sel  = a_word == CNT_ADDR;

   // RAM write port; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (we && ram_sel) mem[a_word[AW+1:2]] <= wd;
   end

   // GPIO output register
   always_ff @(posedge clk) begin
      if (!reset)                gpio_out <= 8'h00;
      else if (we && gpio_sel)   gpio_out <= wd[7:0];
   end

   // free-running cycle counter, loadable by the core
   always_ff @(posedge clk) begin
      if (!reset)                cycle_cnt <= 32'h0;
      else if (we && cnt_sel)    cycle_cnt <= wd;
      else                       cycle_cnt <= cycle_cnt + 32'h1;
   end

`ifdef DMEM_UART_EN
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [PW:0]   FIFO_FULL_CNT = FIFO_DEPTH[PW:0];
   localparam logic [TW-1:0] TMR_LAST      = TW'(CLKS_PER_BIT - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   fifo_cnt;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic [1:0]    state;
   logic [TW-1:0] bit_tmr;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;
   logic          bit_end;
   logic          udata_sel;
   logic          ustat_sel;
   logic [31:0]   uart_status;

   assign udata_sel  = a_word == UDATA_ADDR;
   assign ustat_sel  = a_word == USTAT_ADDR;
   assign fifo_full  = fifo_cnt == FIFO_FULL_CNT;
   assign fifo_empty = fifo_cnt == '0;
   assign bit_end    = bit_tmr == TMR_LAST;

   // a byte leaves the FIFO when idle, or at the very end of a stop bit
   assign pop  = !fifo_empty && (state == S_IDLE || (state == S_STOP && bit_end));
   // a full FIFO still takes the byte when a slot frees on the same edge
   assign push = we && udata_sel && (!fifo_full || pop);

   assign uart_status = {21'b0, 4'(fifo_cnt), 4'b0, (state != S_IDLE), fifo_empty, fifo_full};

   // FIFO storage; stale entries are harmless since occupancy gates reads
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= wd[7:0];
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // transmitter sequencing; reset aborts any frame in flight
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= S_IDLE;
         bit_tmr <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               bit_tmr <= '0;
               if (pop) begin
                  shift <= fifo_mem[rd_ptr];
                  state <= S_START;
               end
            end
            S_START: begin
               if (bit_end) begin
                  bit_tmr <= '0;
                  bit_idx <= '0;
                  state   <= S_DATA;
               end else begin
                  bit_tmr <= bit_tmr + 1'b1;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  bit_tmr <= '0;
                  shift   <= shift >> 1;
                  if (bit_idx == 3'd7) state <= S_STOP;
                  else                 bit_idx <= bit_idx + 1'b1;
               end else begin
                  bit_tmr <= bit_tmr + 1'b1;
               end
            end
            default: begin
               if (bit_end) begin
                  bit_tmr <= '0;
                  if (pop) begin
                     shift <= fifo_mem[rd_ptr];
                     state <= S_START;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  bit_tmr <= bit_tmr + 1'b1;
               end
            end
         endcase
      end
   end

   // serial line level follows the frame phase
   always_comb begin
      uart_tx = 1'b1;
      if (state == S_START)     uart_tx = 1'b0;
      else if (state == S_DATA) uart_tx = shift[0];
   end
`else
   assign uart_tx = 1'b1;
`endif

   // combinational read mux; UART data and unmapped addresses read 0
   always_comb begin
      rd = 32'h0;
      if (ram_sel)       rd = mem[a_word[AW+1:2]];
      else if (gpio_sel) rd = {24'b0, gpio_out};
      else if (cnt_sel)  rd = cycle_cnt;
`ifdef DMEM_UART_EN
      else if (ustat_sel) rd = uart_status;
`endif
   end

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: reset/RAM/GPIO/counter vector table, UART frame,
// FIFO-overflow and reset-abort sequences, then randomized traffic, all
// checked every cycle against a frame-position reference model.
module tb_dmem_mmio;

   localparam int C  = 4;
   localparam int FD = 4;
`ifdef DMEM_UART_EN
   localparam bit UART_EN = 1'b1;
`else
   localparam bit UART_EN = 1'b0;
`endif

   localparam logic [31:0] GPIO  = 32'hFFFF_0000;
   localparam logic [31:0] CNT   = 32'hFFFF_0004;
   localparam logic [31:0] UDATA = 32'hFFFF_0008;
   localparam logic [31:0] STAT  = 32'hFFFF_000C;

   logic        clk;
   logic        reset;
   logic        we;
   logic [31:0] a;
   logic [31:0] wd;
   logic [31:0] rd;
   logic [7:0]  gpio_out;
   logic        uart_tx;

   dmem_mmio #(.DEPTH(64), .FIFO_DEPTH(FD), .CLKS_PER_BIT(C)) dut (
      .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd),
      .rd(rd), .gpio_out(gpio_out), .uart_tx(uart_tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   bit          m_init = 1'b0;
   logic [31:0] m_mem [64];
   bit          m_val [64];
   logic [7:0]  m_gpio;
   logic [31:0] m_cnt;
   logic [7:0]  m_q [$];
   bit          m_busy;
   int          m_pos;
   logic [7:0]  m_byte;

   logic [31:0] rd_s;
   logic        tx_s;

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %h expected %h at %0t", nm, idx, act, exp, $time);
      end
   endtask

   function automatic logic model_tx();
      if (!m_busy)            return 1'b1;
      if (m_pos < C)          return 1'b0;
      if (m_pos < 9 * C)      return m_byte[(m_pos - C) / C];
      return 1'b1;
   endfunction

   task automatic model_read(input logic [31:0] addr, output logic [31:0] e, output bit known);
      logic [31:0] w;
      int occ;
      w = addr & ~32'h3;
      known = 1'b1;
      e = 32'h0;
      if (w < 32'd256) begin
         known = m_val[w[7:2]];
         e = m_mem[w[7:2]];
      end else if (w == GPIO) begin
         e = {24'h0, m_gpio};
      end else if (w == CNT) begin
         e = m_cnt;
      end else if (w == STAT && UART_EN) begin
         occ = m_q.size();
         e = 32'(occ * 128 + (m_busy ? 4 : 0) + (occ == 0 ? 2 : 0) + (occ == FD ? 1 : 0));
      end
   endtask

   task automatic model_edge(input logic r, input logic w, input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] wa;
      bit pop;
      bit accept;
      wa = addr & ~32'h3;
      if (w && wa < 32'd256) begin
         m_mem[wa[7:2]] = data;
         m_val[wa[7:2]] = 1'b1;
      end
      if (!r) begin
         m_init = 1'b1;
         m_gpio = 8'h00;
         m_cnt  = 32'h0;
         m_q.delete();
         m_busy = 1'b0;
         m_pos  = 0;
         return;
      end
      if (!m_init) return;
      pop    = UART_EN && m_q.size() > 0 && (!m_busy || m_pos == 10 * C - 1);
      accept = UART_EN && w && wa == UDATA && (m_q.size() < FD || pop);
      m_cnt  = (w && wa == CNT) ? data : m_cnt + 32'h1;
      if (w && wa == GPIO) m_gpio = data[7:0];
      if (pop) begin
         m_byte = m_q.pop_front();
         m_busy = 1'b1;
         m_pos  = 0;
      end else if (m_busy) begin
         if (m_pos == 10 * C - 1) m_busy = 1'b0;
         else                     m_pos++;
      end
      if (accept) m_q.push_back(data[7:0]);
   endtask

   // one clock cycle: drive, sample mid-cycle against the model, clock, update model
   task automatic step(input logic r, input logic w, input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] e;
      bit known;
      reset = r;
      we    = w;
      a     = addr;
      wd    = data;
      #1;
      rd_s = rd;
      tx_s = uart_tx;
      if (m_init) begin
         model_read(addr, e, known);
         if (known) chk("rd", int'(addr[15:0]), rd, e);
         chk("uart_tx", m_pos, {31'h0, uart_tx}, {31'h0, model_tx()});
         chk("gpio_out", 0, {24'h0, gpio_out}, {24'h0, m_gpio});
      end
      @(posedge clk);
      model_edge(r, w, addr, data);
      #1;
   endtask

   typedef struct {
      logic        r;
      logic        w;
      logic [31:0] addr;
      logic [31:0] data;
      logic        c;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [23];

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_chk, n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] frame;
      logic       exp_tx;
      int         busy_n;
      int         low_n;
      logic [31:0] ra;
      logic        rw;

      reset = 1'b0;
      we    = 1'b0;
      a     = 32'h0;
      wd    = 32'h0;
      for (int i = 0; i < 64; i++) m_val[i] = 1'b0;

      tbl[0]  = '{1'b0, 1'b0, GPIO,           32'h0,         1'b0, 32'h0};
      tbl[1]  = '{1'b0, 1'b0, GPIO,           32'h0,         1'b1, 32'h0};
      tbl[2]  = '{1'b1, 1'b0, CNT,            32'h0,         1'b1, 32'h0};
      tbl[3]  = '{1'b1, 1'b0, STAT,           32'h0,         1'b1, UART_EN ? 32'h2 : 32'h0};
      tbl[4]  = '{1'b1, 1'b1, 32'h10,         32'hDEADBEEF,  1'b0, 32'h0};
      tbl[5]  = '{1'b1, 1'b0, CNT,            32'h0,         1'b1, 32'h3};
      tbl[6]  = '{1'b1, 1'b0, 32'h10,         32'h0,         1'b1, 32'hDEADBEEF};
      tbl[7]  = '{1'b1, 1'b0, 32'h13,         32'h0,         1'b1, 32'hDEADBEEF};
      tbl[8]  = '{1'b1, 1'b0, 32'h8000_0000,  32'h0,         1'b1, 32'h0};
      tbl[9]  = '{1'b1, 1'b1, GPIO,           32'h1234_56A5, 1'b0, 32'h0};
      tbl[10] = '{1'b1, 1'b0, GPIO,           32'h0,         1'b1, 32'hA5};
      tbl[11] = '{1'b1, 1'b1, STAT,           32'hFFFF_FFFF, 1'b0, 32'h0};
      tbl[12] = '{1'b1, 1'b0, STAT,           32'h0,         1'b1, UART_EN ? 32'h2 : 32'h0};
      tbl[13] = '{1'b1, 1'b1, 32'hFFFF_0010,  32'h1234,      1'b0, 32'h0};
      tbl[14] = '{1'b1, 1'b0, 32'hFFFF_0010,  32'h0,         1'b1, 32'h0};
      tbl[15] = '{1'b1, 1'b0, UDATA,          32'h0,         1'b1, 32'h0};
      tbl[16] = '{1'b1, 1'b1, 32'hFC,         32'h1111_2222, 1'b0, 32'h0};
      tbl[17] = '{1'b1, 1'b0, 32'hFF,         32'h0,         1'b1, 32'h1111_2222};
      tbl[18] = '{1'b1, 1'b0, 32'h100,        32'h0,         1'b1, 32'h0};
      tbl[19] = '{1'b1, 1'b1, CNT,            32'hFFFF_FFFE, 1'b0, 32'h0};
      tbl[20] = '{1'b1, 1'b0, CNT,            32'h0,         1'b1, 32'hFFFF_FFFE};
      tbl[21] = '{1'b1, 1'b0, CNT,            32'h0,         1'b1, 32'hFFFF_FFFF};
      tbl[22] = '{1'b1, 1'b0, CNT,            32'h0,         1'b1, 32'h0};

      for (int i = 0; i < 23; i++) begin
         step(tbl[i].r, tbl[i].w, tbl[i].addr, tbl[i].data);
         if (tbl[i].c) chk("table", i, rd_s, tbl[i].exp);
         if (i == 2) chk("reset_tx", i, {31'h0, tx_s}, 32'h1);
      end

      // single frame of 0x5A: start, 8 data bits LSB first, stop, then idle
      frame = {1'b1, 8'h5A, 1'b0};
      step(1'b1, 1'b1, UDATA, 32'h0000_005A);
      step(1'b1, 1'b0, STAT, 32'h0);
      for (int j = 0; j <= 40; j++) begin
         step(1'b1, 1'b0, STAT, 32'h0);
         exp_tx = (j < 40 && UART_EN) ? frame[j / C] : 1'b1;
         chk("frame_5a", j, {31'h0, tx_s}, {31'h0, exp_tx});
      end

      // overflow: six pushes, sixth dropped, five frames back to back
      for (int i = 1; i <= 6; i++) step(1'b1, 1'b1, UDATA, 32'(i));
      busy_n = 0;
      for (int i = 0; i < 400; i++) begin
         step(1'b1, 1'b0, STAT, 32'h0);
         if (i == 0) chk("status_full", i, rd_s, UART_EN ? 32'h205 : 32'h0);
         if (rd_s[2]) busy_n++;
         else if (busy_n > 0) break;
      end
      chk("busy_cycles", 0, 32'(busy_n), UART_EN ? 32'd196 : 32'd0);

      // reset in the middle of a data bit aborts the frame and flushes the FIFO
      step(1'b1, 1'b1, UDATA, 32'h3C);
      step(1'b1, 1'b1, UDATA, 32'h77);
      for (int i = 0; i < 11; i++) step(1'b1, 1'b0, STAT, 32'h0);
      step(1'b0, 1'b0, STAT, 32'h0);
      step(1'b1, 1'b0, STAT, 32'h0);
      chk("abort_tx", 0, {31'h0, tx_s}, 32'h1);
      chk("abort_status", 0, rd_s, UART_EN ? 32'h2 : 32'h0);
      low_n = 0;
      for (int i = 0; i < 60; i++) begin
         step(1'b1, 1'b0, STAT, 32'h0);
         if (!tx_s) low_n++;
      end
      chk("abort_quiet", 0, 32'(low_n), 32'h0);

      // randomized traffic against the model
      for (int i = 0; i < 2500; i++) begin
         case ($urandom_range(0, 7))
            0, 1:    ra = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom)};
            2:       ra = GPIO;
            3:       ra = CNT;
            4, 5:    ra = UDATA;
            6:       ra = STAT;
            default: ra = $urandom;
         endcase
         rw = ($urandom_range(0, 2) == 0);
         step(($urandom_range(0, 399) != 0), rw, ra, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
